pc_seq: RTL and testbench

- Parametrised successor to the 16-bit Hack program counter.
- Holds the current instruction address and selects the next one each cycle from: hold, increment, absolute load, PC-relative branch, subroutine call or return.
- Contains an internal return-address stack (LIFO) for call/return.
- Sits between the CPU control decode and instruction ROM address input; out drives ROM address directly.

---
 rtl/pc_pkg.sv | 16 +
 rtl/pc_seq_if.sv | 29 ++
 rtl/pc_seq_ret_stack.sv | 58 +++++
 rtl/pc_seq.sv | 124 ++++++++++++
 tb/tb_pc_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: next-address operation encoding.
package pc_pkg;

  localparam int PC_OP_W = 3;

  // Codes 6 and 7 are reserved and decode as a hold.
  typedef enum logic [PC_OP_W-1:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_LOAD = 3'd2,
    PC_REL  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_seq_if.sv
// Control-decode <-> program-counter bus: operation request in, address and stack status out.
interface pc_seq_if
  import pc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) ();

  logic                       en;
  logic [PC_OP_W-1:0]         op;
  logic [WIDTH-1:0]           in;
  logic [WIDTH-1:0]           out;
  logic [$clog2(DEPTH+1)-1:0] depth;
  logic                       stk_full;
  logic                       stk_empty;
  logic                       err;
  logic                       ovf;

  modport master (
    output en, op, in,
    input  out, depth, stk_full, stk_empty, err, ovf
  );

  modport slave (
    input  en, op, in,
    output out, depth, stk_full, stk_empty, err, ovf
  );

endinterface

// File: rtl/pc_seq_ret_stack.sv
// Return-address LIFO for pc_seq; silently ignores push-when-full and pop-when-empty.
module pc_ret_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] wr_idx, top_idx;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_idx  = IDX_W'(cnt_q);
  assign top_idx = IDX_W'(cnt_q - CNT_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // NOTE: the storage array carries no reset; the count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  assign top_o   = empty_o ? '0 : mem_q[top_idx];
  assign depth_o = cnt_q;

endmodule

// File: rtl/pc_seq.sv
// Parametrised program counter with call/return stack. Optional sticky wrap flag
// is built only when PC_SEQ_OVF_EN is defined; otherwise ovf is tied low.
module pc_seq
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic     clk,
  input logic     reset_n,
  pc_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  pc_op_t           op;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] inc_val, rel_val, stk_top;
  logic [CNT_W-1:0] stk_depth;
  logic             stk_full, stk_empty;
  logic             push, pop;

  assign op      = pc_op_t'(bus.op);
  assign inc_val = pc_q + WIDTH'(1);
  assign rel_val = pc_q + bus.in;

  // NOTE: every combinational output gets a default first so no path leaves a latch.
  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    if (bus.en) begin
      case (op)
        PC_INC:  pc_d = inc_val;
        PC_LOAD: pc_d = bus.in;
        PC_REL:  pc_d = rel_val;
        PC_CALL: begin
          if (stk_full) begin
            err_d = 1'b1;
          end else begin
            push = 1'b1;
            pc_d = bus.in;
          end
        end
        PC_RET: begin
          if (stk_empty) begin
            err_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = stk_top;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_ret_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (inc_val),
    .top_o       (stk_top),
    .depth_o     (stk_depth),
    .full_o      (stk_full),
    .empty_o     (stk_empty)
  );

`ifdef PC_SEQ_OVF_EN
  logic ovf_q, ovf_set, rel_carry;

  // With a sign-extended offset, a wrap is the add carry disagreeing with the offset sign.
  always_comb begin
    rel_carry = (pc_q[WIDTH-1] & bus.in[WIDTH-1]) |
                ((pc_q[WIDTH-1] | bus.in[WIDTH-1]) & ~rel_val[WIDTH-1]);
    ovf_set   = 1'b0;
    if (bus.en) begin
      case (op)
        PC_INC:  ovf_set = &pc_q;
        PC_REL:  ovf_set = rel_carry ^ bus.in[WIDTH-1];
        PC_CALL: ovf_set = push && (&pc_q);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_set;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.out       = pc_q;
  assign bus.depth     = stk_depth;
  assign bus.stk_full  = stk_full;
  assign bus.stk_empty = stk_empty;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq: increment, relative branch, call/return nesting,
// stack overflow/underflow, enable hold, address wrap and mid-sequence reset.
module tb_pc_seq;
  import pc_pkg::*;

  localparam int               WIDTH = 16;
  localparam int               DEPTH = 8;
  localparam logic [WIDTH-1:0] RVEC  = 16'h0100;

`ifdef PC_SEQ_OVF_EN
  localparam logic OVF_WRAP = 1'b1;
`else
  localparam logic OVF_WRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  pc_seq_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pc_seq #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VEC (RVEC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Apply one operation across one rising edge; outputs are sampled 1 time unit later.
  task automatic step(input logic en, input pc_op_t op, input logic [WIDTH-1:0] in);
    bus.en = en;
    bus.op = op;
    bus.in = in;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(1'b1, PC_HOLD, '0);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b1;
    bus.en  = 1'b0;
    bus.op  = PC_HOLD;
    bus.in  = '0;
    @(negedge clk);

    // Reset state and increment
    do_reset();
    check("rst_out", bus.out, 32'h0100);
    check("rst_depth", bus.depth, 0);
    check("rst_empty", bus.stk_empty, 1);
    check("rst_full", bus.stk_full, 0);
    check("rst_err", bus.err, 0);
    check("rst_ovf", bus.ovf, 0);
    step(1'b1, PC_INC, '0); check("inc1", bus.out, 32'h0101);
    step(1'b1, PC_INC, '0); check("inc2", bus.out, 32'h0102);
    step(1'b1, PC_INC, '0); check("inc3", bus.out, 32'h0103);
    check("inc_depth", bus.depth, 0);
    check("inc_err", bus.err, 0);

    // Relative branch backwards then forwards
    step(1'b1, PC_LOAD, 16'h0010); check("load", bus.out, 32'h0010);
    step(1'b1, PC_REL, 16'hFFFC);  check("rel_neg", bus.out, 32'h000C);
    step(1'b1, PC_REL, 16'h0005);  check("rel_pos", bus.out, 32'h0011);
    check("rel_ovf", bus.ovf, 0);

    // Nested call / return
    step(1'b1, PC_LOAD, 16'h0020);
    step(1'b1, PC_CALL, 16'h0200); check("call1", bus.out, 32'h0200); check("call1_d", bus.depth, 1);
    step(1'b1, PC_CALL, 16'h0300); check("call2", bus.out, 32'h0300); check("call2_d", bus.depth, 2);
    step(1'b1, PC_RET, '0);        check("ret1", bus.out, 32'h0201);  check("ret1_d", bus.depth, 1);
    step(1'b1, PC_RET, '0);        check("ret2", bus.out, 32'h0021);  check("ret2_d", bus.depth, 0);
    check("ret_empty", bus.stk_empty, 1);
    check("ret_err", bus.err, 0);

    // Reserved op behaves as hold
    bus.en = 1'b1; bus.op = 3'd6; bus.in = 16'h5555;
    @(posedge clk); #1;
    check("rsvd6", bus.out, 32'h0021);

    // Stack overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, PC_CALL, WIDTH'(i * 16'h0010));
    end
    check("ovfl_out8", bus.out, 32'h0080);
    check("ovfl_full", bus.stk_full, 1);
    check("ovfl_d8", bus.depth, DEPTH);
    check("ovfl_err0", bus.err, 0);
    step(1'b1, PC_CALL, 16'hABCD);
    check("ovfl_out9", bus.out, 32'h0080);
    check("ovfl_d9", bus.depth, DEPTH);
    check("ovfl_err1", bus.err, 1);
    // Top entry is the return from the 7th-level call at 0x0070
    step(1'b1, PC_RET, '0);
    check("ovfl_ret", bus.out, 32'h0071);
    check("ovfl_ret_d", bus.depth, DEPTH - 1);

    // Stack underflow
    do_reset();
    step(1'b1, PC_RET, '0);
    check("unfl_out", bus.out, 32'h0100);
    check("unfl_d", bus.depth, 0);
    check("unfl_err", bus.err, 1);
    step(1'b1, PC_INC, '0);
    check("unfl_inc", bus.out, 32'h0101);
    check("unfl_sticky", bus.err, 1);

    // Enable hold and wrap
    step(1'b0, PC_LOAD, 16'h1234); check("en0_out", bus.out, 32'h0101);
    step(1'b0, PC_CALL, 16'h1234); check("en0_d", bus.depth, 0);
    step(1'b1, PC_LOAD, 16'hFFFF); check("wrap_pre", bus.out, 32'hFFFF);
    check("wrap_pre_ovf", bus.ovf, 0);
    step(1'b1, PC_INC, '0);        check("wrap_inc", bus.out, 32'h0000);
    check("wrap_ovf", bus.ovf, OVF_WRAP);
    step(1'b1, PC_REL, 16'hFFFF);  check("wrap_rel", bus.out, 32'hFFFF);
    check("wrap_ovf_sticky", bus.ovf, OVF_WRAP);

    // Reset mid-stack
    do_reset();
    step(1'b1, PC_CALL, 16'h0400);
    step(1'b1, PC_CALL, 16'h0500);
    step(1'b1, PC_CALL, 16'h0600);
    check("mid_d3", bus.depth, 3);
    step(1'b1, PC_RET, '0);        check("mid_ret", bus.out, 32'h0501);
    step(1'b1, PC_CALL, 16'h0700);
    do_reset();
    check("mid_out", bus.out, 32'h0100);
    check("mid_d0", bus.depth, 0);
    check("mid_err", bus.err, 0);
    check("mid_ovf", bus.ovf, 0);
    step(1'b1, PC_RET, '0);
    check("mid_noret", bus.out, 32'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
